// File: rtl/mem_port_arbiter.sv
// Shares the single Avalon-style memory master port between instruction fetch and load/store.
// One requester is granted at a time; every transfer ends in a one-cycle ack or err.
module mem_port_arbiter #(
   parameter int unsigned TIMEOUT = 255,
   parameter int unsigned CNT_W   = 16
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        if_req,
   input  logic [31:0] if_addr,
   output logic [31:0] if_rdata,
   output logic        if_ack,
   output logic        if_err,
   input  logic        d_read,
   input  logic        d_write,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_byteenable,
   output logic [31:0] d_rdata,
   output logic        d_ack,
   output logic        d_err,
   output logic [31:0] mem_address,
   output logic        mem_read,
   output logic        mem_write,
   output logic [31:0] mem_writedata,
   output logic [3:0]  mem_byteenable,
   input  logic [31:0] mem_readdata,
   input  logic        mem_waitrequest,
   output logic        busy
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      FETCH = 2'd1,
      DATA  = 2'd2,
      RESP  = 2'd3
   } state_t;

   localparam logic [CNT_W-1:0] STALL_MAX = CNT_W'(TIMEOUT);

   state_t           state, state_nxt;
   logic             last_data, last_data_nxt;
   logic             misaligned, misaligned_nxt;
   logic [CNT_W-1:0] stall_cnt, stall_cnt_nxt;

   logic [31:0]      if_rdata_nxt, d_rdata_nxt;
   logic             if_ack_nxt, if_err_nxt, d_ack_nxt, d_err_nxt;
   logic [31:0]      mem_address_nxt, mem_writedata_nxt;
   logic             mem_read_nxt, mem_write_nxt;
   logic [3:0]       mem_byteenable_nxt;
   logic             busy_nxt;

   logic             data_pend, data_mis, fetch_mis;
   logic             grant_data, grant_fetch;
   logic             fin_ok, fin_err;

   // Round-robin on ties: the requester not granted last time wins.
   always_comb begin : arbitrate
      data_pend   = d_read | d_write;
      data_mis    = (d_addr[1:0] != 2'b00) && (d_byteenable == 4'hF);
      fetch_mis   = (if_addr[1:0] != 2'b00);
      grant_data  = data_pend && (!if_req || !last_data);
      grant_fetch = if_req && (!data_pend || last_data);
   end

   always_comb begin : fsm_next
      state_nxt          = state;
      last_data_nxt      = last_data;
      misaligned_nxt     = misaligned;
      stall_cnt_nxt      = stall_cnt;
      if_rdata_nxt       = if_rdata;
      d_rdata_nxt        = d_rdata;
      if_ack_nxt         = 1'b0;
      if_err_nxt         = 1'b0;
      d_ack_nxt          = 1'b0;
      d_err_nxt          = 1'b0;
      mem_address_nxt    = mem_address;
      mem_read_nxt       = mem_read;
      mem_write_nxt      = mem_write;
      mem_writedata_nxt  = mem_writedata;
      mem_byteenable_nxt = mem_byteenable;
      fin_ok             = 1'b0;
      fin_err            = 1'b0;

      case (state)
         IDLE: begin
            if (grant_data) begin
               state_nxt          = DATA;
               last_data_nxt      = 1'b1;
               misaligned_nxt     = data_mis;
               stall_cnt_nxt      = '0;
               mem_address_nxt    = {d_addr[31:2], 2'b00};
               mem_read_nxt       = d_read && !data_mis;
               mem_write_nxt      = d_write && !data_mis;
               mem_writedata_nxt  = d_wdata;
               mem_byteenable_nxt = d_byteenable;
            end else if (grant_fetch) begin
               state_nxt          = FETCH;
               last_data_nxt      = 1'b0;
               misaligned_nxt     = fetch_mis;
               stall_cnt_nxt      = '0;
               mem_address_nxt    = {if_addr[31:2], 2'b00};
               mem_read_nxt       = !fetch_mis;
               mem_write_nxt      = 1'b0;
               mem_byteenable_nxt = 4'hF;
            end
         end
         FETCH, DATA: begin
            // Misaligned grants never strobe the bus and fail on the next edge.
            if (misaligned) begin
               fin_err = 1'b1;
            end else if (!mem_waitrequest) begin
               fin_ok        = 1'b1;
               mem_read_nxt  = 1'b0;
               mem_write_nxt = 1'b0;
               if (mem_read) begin
                  if (state == DATA) d_rdata_nxt  = mem_readdata;
                  else               if_rdata_nxt = mem_readdata;
               end
            end else if (stall_cnt == STALL_MAX) begin
               fin_err       = 1'b1;
               mem_read_nxt  = 1'b0;
               mem_write_nxt = 1'b0;
            end else begin
               stall_cnt_nxt = stall_cnt + CNT_W'(1);
            end
         end
         RESP: begin
            state_nxt = IDLE;
         end
         default: begin
            state_nxt = IDLE;
         end
      endcase

      if (fin_ok || fin_err) state_nxt = RESP;
      if_ack_nxt = fin_ok  && (state == FETCH);
      if_err_nxt = fin_err && (state == FETCH);
      d_ack_nxt  = fin_ok  && (state == DATA);
      d_err_nxt  = fin_err && (state == DATA);
      busy_nxt   = (state_nxt != IDLE);
   end

   always_ff @(posedge clk) begin : regs
      if (!reset_n) begin
         state          <= IDLE;
         last_data      <= 1'b0;
         misaligned     <= 1'b0;
         stall_cnt      <= '0;
         if_rdata       <= '0;
         if_ack         <= 1'b0;
         if_err         <= 1'b0;
         d_rdata        <= '0;
         d_ack          <= 1'b0;
         d_err          <= 1'b0;
         mem_address    <= '0;
         mem_read       <= 1'b0;
         mem_write      <= 1'b0;
         mem_writedata  <= '0;
         mem_byteenable <= '0;
         busy           <= 1'b0;
      end else begin
         state          <= state_nxt;
         last_data      <= last_data_nxt;
         misaligned     <= misaligned_nxt;
         stall_cnt      <= stall_cnt_nxt;
         if_rdata       <= if_rdata_nxt;
         if_ack         <= if_ack_nxt;
         if_err         <= if_err_nxt;
         d_rdata        <= d_rdata_nxt;
         d_ack          <= d_ack_nxt;
         d_err          <= d_err_nxt;
         mem_address    <= mem_address_nxt;
         mem_read       <= mem_read_nxt;
         mem_write      <= mem_write_nxt;
         mem_writedata  <= mem_writedata_nxt;
         mem_byteenable <= mem_byteenable_nxt;
         busy           <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter against a transaction-level model of the arbitration,
// alignment and timeout rules, plus the directed reset-vector, tie, write, error and reset cases.
module tb_mem_port_arbiter;
   localparam int unsigned TO = 4;

   logic        clk, reset_n;
   logic        if_req;
   logic [31:0] if_addr, if_rdata;
   logic        if_ack, if_err;
   logic        d_read, d_write;
   logic [31:0] d_addr, d_wdata, d_rdata;
   logic [3:0]  d_byteenable;
   logic        d_ack, d_err;
   logic [31:0] mem_address, mem_writedata, mem_readdata;
   logic        mem_read, mem_write, mem_waitrequest;
   logic [3:0]  mem_byteenable;
   logic        busy;

   int          errors, checks;
   bit          m_last_data;
   logic [31:0] m_if_rdata, m_d_rdata;
   int          if_wait, d_wait;

   mem_port_arbiter #(.TIMEOUT(TO), .CNT_W(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ack(if_ack), .if_err(if_err),
      .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_byteenable(d_byteenable), .d_rdata(d_rdata), .d_ack(d_ack), .d_err(d_err),
      .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
      .mem_writedata(mem_writedata), .mem_byteenable(mem_byteenable),
      .mem_readdata(mem_readdata), .mem_waitrequest(mem_waitrequest), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Outputs expected in any cycle with no transfer or response in progress.
   task automatic check_quiet(input string tag);
      check_eq({tag, "_busy"}, 32'(busy), 32'd0);
      check_eq({tag, "_strobes"}, 32'({mem_read, mem_write}), 32'd0);
      check_eq({tag, "_resp"}, 32'({if_ack, if_err, d_ack, d_err}), 32'd0);
      check_eq({tag, "_if_rdata"}, if_rdata, m_if_rdata);
      check_eq({tag, "_d_rdata"}, d_rdata, m_d_rdata);
   endtask

   function automatic logic [31:0] rand_addr();
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      return a;
   endfunction

   // Serves one grant starting from an IDLE-cycle negedge; returns at the following IDLE negedge.
   task automatic serve(input bit hold, input logic [31:0] rdv);
      bit          dp, win_d, mis, ok, rd;
      logic [31:0] ea, ew;
      logic [3:0]  eb;
      int          n;
      dp = d_read | d_write;
      if (!dp && !if_req) begin
         @(negedge clk);
         check_quiet("no_req");
         return;
      end
      win_d = (dp && if_req) ? !m_last_data : dp;
      m_last_data = win_d;
      if (win_d) begin
         mis = (d_addr[1:0] != 2'b00) && (d_byteenable == 4'hF);
         ea  = {d_addr[31:2], 2'b00};
         eb  = d_byteenable;
         ew  = d_wdata;
         rd  = d_read;
         n   = d_wait;
      end else begin
         mis = (if_addr[1:0] != 2'b00);
         ea  = {if_addr[31:2], 2'b00};
         eb  = 4'hF;
         ew  = 32'd0;
         rd  = 1'b1;
         n   = if_wait;
      end
      ok = !mis && (n <= int'(TO));
      @(negedge clk);
      if (mis) begin
         check_eq("mis_strobes", 32'({mem_read, mem_write}), 32'd0);
         check_eq("mis_busy", 32'(busy), 32'd1);
         @(negedge clk);
      end else begin
         for (int k = 0; k <= int'(TO); k++) begin
            check_eq("strobe", 32'({mem_read, mem_write}), 32'({rd, !rd}));
            check_eq("address", mem_address, ea);
            check_eq("byteenable", 32'(mem_byteenable), 32'(eb));
            if (!rd) check_eq("writedata", mem_writedata, ew);
            check_eq("busy_xfer", 32'(busy), 32'd1);
            check_eq("resp_early", 32'({if_ack, if_err, d_ack, d_err}), 32'd0);
            if (k >= n) begin
               mem_waitrequest = 1'b0;
               mem_readdata    = rdv;
            end else begin
               mem_waitrequest = 1'b1;
               mem_readdata    = $urandom;
            end
            @(negedge clk);
            if (k >= n) break;
         end
      end
      mem_waitrequest = 1'b0;
      mem_readdata    = $urandom;
      if (ok && rd) begin
         if (win_d) m_d_rdata = rdv;
         else       m_if_rdata = rdv;
      end
      check_eq("resp_strobes", 32'({mem_read, mem_write}), 32'd0);
      check_eq("resp_busy", 32'(busy), 32'd1);
      check_eq("if_ack", 32'(if_ack), 32'(!win_d && ok));
      check_eq("if_err", 32'(if_err), 32'(!win_d && !ok));
      check_eq("d_ack", 32'(d_ack), 32'(win_d && ok));
      check_eq("d_err", 32'(d_err), 32'(win_d && !ok));
      check_eq("resp_if_rdata", if_rdata, m_if_rdata);
      check_eq("resp_d_rdata", d_rdata, m_d_rdata);
      if (!hold) begin
         if (win_d) begin
            d_read  = 1'b0;
            d_write = 1'b0;
         end else begin
            if_req = 1'b0;
         end
      end
      @(negedge clk);
      check_quiet("gap");
   endtask

   initial begin
      errors = 0; checks = 0;
      reset_n = 1'b0;
      if_req = 1'b0; if_addr = '0;
      d_read = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_byteenable = '0;
      mem_readdata = '0; mem_waitrequest = 1'b0;
      m_last_data = 1'b0; m_if_rdata = '0; m_d_rdata = '0;
      if_wait = 0; d_wait = 0;

      repeat (3) @(negedge clk);
      check_quiet("reset");
      check_eq("reset_addr", mem_address, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);
      check_quiet("post_reset");

      // Boot fetch from the reset vector, zero-wait slave.
      if_req = 1'b1; if_addr = 32'hBFC0_0000; if_wait = 0;
      serve(1'b0, 32'h3C1D_0000);
      check_eq("boot_word", if_rdata, 32'h3C1D_0000);

      // Both requesters held continuously: grants alternate starting with data.
      if_req = 1'b1; if_addr = 32'hBFC0_0004; if_wait = 0;
      d_read = 1'b1; d_addr = 32'h0000_1000; d_byteenable = 4'hF; d_wait = 0;
      for (int i = 0; i < 4; i++) serve(1'b1, $urandom);
      if_req = 1'b0; d_read = 1'b0;
      @(negedge clk);
      check_quiet("tie_done");

      // Partial-word write with a 3-cycle stall.
      d_write = 1'b1; d_addr = 32'h0000_2000; d_wdata = 32'hDEAD_BEEF;
      d_byteenable = 4'b0011; d_wait = 3;
      serve(1'b0, $urandom);

      // Misaligned fetch.
      if_req = 1'b1; if_addr = 32'hBFC0_0002; if_wait = 0;
      serve(1'b0, $urandom);

      // Stall exactly at the limit completes; one more cycle times out; stuck slave times out.
      d_read = 1'b1; d_addr = 32'h0000_3000; d_byteenable = 4'hF; d_wait = int'(TO);
      serve(1'b0, $urandom);
      d_read = 1'b1; d_addr = 32'h0000_3004; d_wait = int'(TO) + 1;
      serve(1'b0, $urandom);
      d_read = 1'b1; d_addr = 32'h0000_4000; d_wait = 1000;
      serve(1'b0, $urandom);

      // Reset asserted in the 2nd cycle of a stalled read.
      d_read = 1'b1; d_addr = 32'h0000_5000; d_byteenable = 4'hF;
      @(negedge clk);
      check_eq("rst_mid_strobe1", 32'(mem_read), 32'd1);
      mem_waitrequest = 1'b1;
      @(negedge clk);
      check_eq("rst_mid_strobe2", 32'(mem_read), 32'd1);
      reset_n = 1'b0;
      d_read = 1'b0;
      m_last_data = 1'b0; m_if_rdata = '0; m_d_rdata = '0;
      @(negedge clk);
      mem_waitrequest = 1'b0;
      check_quiet("rst_mid");
      reset_n = 1'b1;
      @(negedge clk);
      check_quiet("rst_release");
      if_req = 1'b1; if_addr = 32'hBFC0_0008; if_wait = 1;
      serve(1'b0, $urandom);
      d_read = 1'b1; d_addr = 32'h0000_6000; d_byteenable = 4'hF; d_wait = 0;
      serve(1'b0, $urandom);

      // Randomized mix of requests, lanes, alignment, stalls and holds.
      for (int it = 0; it < 120; it++) begin
         if (!if_req && ($urandom_range(0, 1) == 1)) begin
            if_req  = 1'b1;
            if_addr = rand_addr();
            if_wait = $urandom_range(0, 6);
         end
         if (!(d_read || d_write) && ($urandom_range(0, 1) == 1)) begin
            if ($urandom_range(0, 1) == 1) d_read = 1'b1;
            else                           d_write = 1'b1;
            d_addr       = rand_addr();
            d_wdata      = $urandom;
            d_byteenable = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'hF;
            d_wait       = $urandom_range(0, 6);
         end
         serve($urandom_range(0, 3) == 0, $urandom);
      end

      if_req = 1'b0; d_read = 1'b0; d_write = 1'b0;
      @(negedge clk);
      check_quiet("final");
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
